// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables, lane width and lookup helper.
package aes_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [BYTE_W-1:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Forward or inverse substitution of one byte.
    function automatic logic [BYTE_W-1:0] sbox_lookup(input logic [BYTE_W-1:0] b, input logic inv);
        return inv ? INV_SBOX[b] : SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One-byte combinational S-box / inverse S-box lane.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              inv,
    output logic [BYTE_W-1:0] byte_out_c
);

    // Table lookup selected by mode.
    assign byte_out_c = sbox_lookup(byte_in, inv);

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane pipelined AES SubBytes with per-beat mode and valid/ready stages.
module aes_subbytes_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W*LANES-1:0]   in_data,
    input  logic                      in_inv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*LANES-1:0]   out_data,
    output logic                      out_inv,
    output logic                      busy,
    output logic [15:0]               beat_count
);

    localparam int unsigned DATA_W = BYTE_W * LANES;

    logic [DATA_W-1:0] sub_c;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] inv_q;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [STAGES-1:0] ld_c;
    logic [STAGES-1:0] vin_c;
    logic [STAGES-1:0] invin_c;
    logic [DATA_W-1:0] din_c [STAGES];
    logic [STAGES-1:0] v_nxt_c;
    logic              busy_q;
    logic [15:0]       count_q;

    // Per-lane substitution feeding stage 1.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        aes_sbox_lane u_lane (
            .byte_in    (in_data[k*BYTE_W +: BYTE_W]),
            .inv        (in_inv),
            .byte_out_c (sub_c[k*BYTE_W +: BYTE_W])
        );
    end

    // A stage may load when out_ready is high or any stage at or after it is empty.
    always_comb begin
        ld_c = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            ld_c[s] = out_ready;
            for (int unsigned t = s; t < STAGES; t++) begin
                if (!v_q[t]) begin
                    ld_c[s] = 1'b1;
                end
            end
        end
    end

    // Stage input selection and next valid vector.
    always_comb begin
        vin_c   = '0;
        invin_c = '0;
        v_nxt_c = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            din_c[s] = '0;
        end
        vin_c[0]   = in_valid;
        invin_c[0] = in_inv;
        din_c[0]   = sub_c;
        for (int unsigned s = 1; s < STAGES; s++) begin
            vin_c[s]   = v_q[s-1];
            invin_c[s] = inv_q[s-1];
            din_c[s]   = d_q[s-1];
        end
        for (int unsigned s = 0; s < STAGES; s++) begin
            v_nxt_c[s] = ld_c[s] ? vin_c[s] : v_q[s];
        end
    end

    // Stage registers, registered busy flag and delivered-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            inv_q   <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                d_q[s] <= '0;
            end
        end else begin
            v_q    <= v_nxt_c;
            busy_q <= |v_nxt_c;
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (ld_c[s] && vin_c[s]) begin
                    d_q[s]   <= din_c[s];
                    inv_q[s] <= invin_c[s];
                end
            end
            if (v_q[STAGES-1] && out_ready) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign in_ready   = ld_c[0];
    assign out_valid  = v_q[STAGES-1];
    assign out_data   = d_q[STAGES-1];
    assign out_inv    = inv_q[STAGES-1];
    assign busy       = busy_q;
    assign beat_count = count_q;

endmodule
